// File: rtl/pio_csr_bank.sv
// pio_csr_bank: PIO control/status register bank between a valid/write bus and NUM_SM state machines
// Ports: bus_* valid/write access with registered read data; sm_* per-SM config, injection and status;
// fifo_stat/fifo_evt FIFO status and sticky debug events; irq_* IRQ flags; intr_raw/irq_out interrupt lines.
module pio_csr_bank #(
  parameter int NUM_SM  = 4,
  parameter int NUM_IRQ = 2,
  parameter int ADDR_W  = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bus_valid_i,
  input  logic                 bus_write_i,
  input  logic [ADDR_W-1:0]    bus_addr_i,
  input  logic [31:0]          bus_wdata_i,
  output logic [31:0]          bus_rdata_o,
  output logic                 bus_rvalid_o,
  output logic [NUM_SM-1:0]    sm_en_o,
  output logic [NUM_SM-1:0]    sm_restart_o,
  output logic [NUM_SM-1:0]    clkdiv_restart_o,
  input  logic [4*NUM_SM-1:0]  fifo_stat_i,
  input  logic [4*NUM_SM-1:0]  fifo_evt_i,
  input  logic [7:0]           irq_set_i,
  input  logic [7:0]           irq_clr_i,
  output logic [7:0]           irq_flags_o,
  output logic [24*NUM_SM-1:0] sm_clkdiv_o,
  output logic [32*NUM_SM-1:0] sm_execctrl_o,
  output logic [16*NUM_SM-1:0] sm_shiftctrl_o,
  output logic [32*NUM_SM-1:0] sm_pinctrl_o,
  input  logic [5*NUM_SM-1:0]  sm_pc_i,
  input  logic [16*NUM_SM-1:0] sm_cur_instr_i,
  output logic [16*NUM_SM-1:0] sm_instr_o,
  output logic [NUM_SM-1:0]    sm_instr_stb_o,
  input  logic [3*NUM_SM-1:0]  intr_raw_i,
  output logic [NUM_IRQ-1:0]   irq_out_o
);
  localparam int N = NUM_SM;
  localparam int W = 3 * NUM_SM;
  localparam int INTR_A = 200 + 24 * N;
  function automatic logic [31:0] sm_a(int i, int off);
    return 32'(200 + 24 * i + off);
  endfunction
  function automatic logic [31:0] irq_a(int n, int off);
    return 32'(INTR_A + 4 + 12 * n + off);
  endfunction
  logic [31:0] addr, fstat, fevt, rdata_d, rdata_q, fdebug_q, fdebug_d;
  logic [N-1:0] en_q, restart_q, cdr_q, stb_q;
  logic [7:0] irq_q, irq_d;
  logic [24*N-1:0] clkdiv_q;
  logic [32*N-1:0] exec_q, pin_q;
  logic [16*N-1:0] shift_q, instr_q;
  logic [W*NUM_IRQ-1:0] inte_q, intf_q, ints;
  logic [NUM_IRQ-1:0] irq_out_q, irq_out_d;
  logic rvalid_q, wr, rd;
  assign addr = 32'(bus_addr_i);
  assign wr = bus_valid_i & bus_write_i;
  assign rd = bus_valid_i & ~bus_write_i;
  always_comb begin
    fstat = '0;
    fevt = '0;
    ints = '0;
    irq_out_d = '0;
    // status/debug word: field k of every SM packed at [8k +: NUM_SM]
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 4; k++) begin
        fstat[8*k+i] = fifo_stat_i[4*i+k];
        fevt[8*k+i] = fifo_evt_i[4*i+k];
      end
    for (int n = 0; n < NUM_IRQ; n++) begin
      ints[W*n+:W] = (intr_raw_i & inte_q[W*n+:W]) | intf_q[W*n+:W];
      irq_out_d[n] = |ints[W*n+:W];
    end
    // hardware set is OR-ed in last so a same-cycle event survives a W1C
    fdebug_d = (fdebug_q & ~(wr && addr == 32'h8 ? bus_wdata_i : 32'h0)) | fevt;
    irq_d = (irq_q & ~(wr && addr == 32'h30 ? bus_wdata_i[7:0] : 8'h0) & ~irq_clr_i) | irq_set_i;
    rdata_d = '0;
    if (addr == 32'h0) rdata_d = 32'(en_q);
    if (addr == 32'h4) rdata_d = fstat;
    if (addr == 32'h8) rdata_d = fdebug_q;
    if (addr == 32'h30) rdata_d = 32'(irq_q);
    if (addr == 32'h44) rdata_d = {10'b0, 6'd32, 4'b0, 4'(NUM_SM), 2'b0, 6'd4};
    for (int i = 0; i < N; i++) begin
      if (addr == sm_a(i, 0)) rdata_d = {clkdiv_q[24*i+:24], 8'h0};
      if (addr == sm_a(i, 4)) rdata_d = exec_q[32*i+:32];
      if (addr == sm_a(i, 8)) rdata_d = {shift_q[16*i+:16], 16'h0};
      if (addr == sm_a(i, 12)) rdata_d = 32'(sm_pc_i[5*i+:5]);
      if (addr == sm_a(i, 16)) rdata_d = 32'(sm_cur_instr_i[16*i+:16]);
      if (addr == sm_a(i, 20)) rdata_d = pin_q[32*i+:32];
    end
    if (addr == 32'(INTR_A)) rdata_d = 32'(intr_raw_i);
    for (int n = 0; n < NUM_IRQ; n++) begin
      if (addr == irq_a(n, 0)) rdata_d = 32'(inte_q[W*n+:W]);
      if (addr == irq_a(n, 4)) rdata_d = 32'(intf_q[W*n+:W]);
      if (addr == irq_a(n, 8)) rdata_d = 32'(ints[W*n+:W]);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q <= '0;
      restart_q <= '0;
      cdr_q <= '0;
      stb_q <= '0;
      fdebug_q <= '0;
      irq_q <= '0;
      clkdiv_q <= {N{24'h000100}};
      exec_q <= {N{32'h0001_F000}};
      shift_q <= {N{16'h000C}};
      pin_q <= {N{32'h1400_0000}};
      instr_q <= '0;
      inte_q <= '0;
      intf_q <= '0;
      irq_out_q <= '0;
      rvalid_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      restart_q <= '0;
      cdr_q <= '0;
      stb_q <= '0;
      fdebug_q <= fdebug_d;
      irq_q <= irq_d;
      irq_out_q <= irq_out_d;
      rvalid_q <= rd;
      if (rd) rdata_q <= rdata_d;
      if (wr && addr == 32'h0) begin
        en_q <= bus_wdata_i[N-1:0];
        restart_q <= bus_wdata_i[8+:N];
        cdr_q <= bus_wdata_i[16+:N];
      end
      for (int i = 0; i < N; i++) begin
        if (wr && addr == sm_a(i, 0)) clkdiv_q[24*i+:24] <= bus_wdata_i[31:8];
        if (wr && addr == sm_a(i, 4)) exec_q[32*i+:32] <= bus_wdata_i & 32'h7FFF_FF9F;
        if (wr && addr == sm_a(i, 8)) shift_q[16*i+:16] <= bus_wdata_i[31:16];
        if (wr && addr == sm_a(i, 16)) begin
          instr_q[16*i+:16] <= bus_wdata_i[15:0];
          stb_q[i] <= 1'b1;
        end
        if (wr && addr == sm_a(i, 20)) pin_q[32*i+:32] <= bus_wdata_i;
      end
      for (int n = 0; n < NUM_IRQ; n++) begin
        if (wr && addr == irq_a(n, 0)) inte_q[W*n+:W] <= bus_wdata_i[W-1:0];
        if (wr && addr == irq_a(n, 4)) intf_q[W*n+:W] <= bus_wdata_i[W-1:0];
      end
    end
  end
  assign bus_rdata_o = rdata_q;
  assign bus_rvalid_o = rvalid_q;
  assign sm_en_o = en_q;
  assign sm_restart_o = restart_q;
  assign clkdiv_restart_o = cdr_q;
  assign irq_flags_o = irq_q;
  assign sm_clkdiv_o = clkdiv_q;
  assign sm_execctrl_o = exec_q;
  assign sm_shiftctrl_o = shift_q;
  assign sm_pinctrl_o = pin_q;
  assign sm_instr_o = instr_q;
  assign sm_instr_stb_o = stb_q;
  assign irq_out_o = irq_out_q;
endmodule
